// File: rtl/snake_cpu_pkg.sv
// Shared opcodes, FSM states, LFSR constants and instruction-field helpers
// for the snake-game CPU core.
package snake_cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_MOV  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JF   = 4'hB;
   localparam logic [3:0] OP_IN   = 4'hC;
   localparam logic [3:0] OP_RND  = 4'hD;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 of the Fibonacci polynomial as a bit mask.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Widest instruction word (DATA_W = 16); narrower words are zero-extended.
   localparam int MAX_INST_W = 24;

   function automatic logic [3:0] inst_op(input logic [MAX_INST_W-1:0] inst, input int inst_w);
      return inst[inst_w-1 -: 4];
   endfunction

   function automatic logic [3:0] inst_ra(input logic [MAX_INST_W-1:0] inst, input int inst_w);
      return inst[inst_w-5 -: 4];
   endfunction

   function automatic logic [3:0] inst_rb(input logic [MAX_INST_W-1:0] inst);
      return inst[3:0];
   endfunction

endpackage

// File: rtl/snake_btn_sync.sv
// Button conditioning: two-flop synchroniser, rising-edge detect and a sticky
// event register that a set wins over a simultaneous clear.
module snake_btn_sync
   import snake_cpu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] btn,
   input  logic         clr,
   output logic [W-1:0] sticky
);

   logic [W-1:0] sync1, sync2, prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         prev   <= '0;
         sticky <= '0;
      end else begin
         sync1  <= btn;
         sync2  <= sync1;
         prev   <= sync2;
         sticky <= (clr ? '0 : sticky) | (sync2 & ~prev);
      end
   end

endmodule

// File: rtl/snake_cpu_core.sv
// Multicycle accumulator/register CPU for the snake game: handshaked fetch,
// inline register file, button events, LFSR source and frame-buffer port.
module snake_cpu_core
   import snake_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int NREGS  = 8,
   parameter int FB_AW  = 3,
   parameter int INST_W = DATA_W + 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_req,
   input  logic [INST_W-1:0] imem_data,
   input  logic              imem_valid,
   input  logic [3:0]        btn,
   output logic              fb_we,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [DATA_W-1:0] fb_data,
   output logic              halted
);

   state_t                state;
   logic [PC_W-1:0]       pc;
   logic [INST_W-1:0]     inst_q;
   logic [DATA_W-1:0]     regs [NREGS];
   logic [DATA_W-1:0]     opa, opb, rd_a, rd_b, wr_data;
   logic                  flag, flag_nxt, wr_en, in_clr;
   logic [15:0]           lfsr;
   logic [3:0]            sticky;
   logic [MAX_INST_W-1:0] inst_ext;
   logic [3:0]            op, ra, rb;
   logic [DATA_W-1:0]     imm;
   logic [DATA_W:0]       sum, diff, sum_imm;

   assign inst_ext  = MAX_INST_W'(inst_q);
   assign op        = inst_op(inst_ext, INST_W);
   assign ra        = inst_ra(inst_ext, INST_W);
   assign rb        = inst_rb(inst_ext);
   assign imm       = inst_q[DATA_W-1:0];
   assign imem_addr = pc;
   assign halted    = (state == HALT);
   assign in_clr    = (state == EXEC) && (op == OP_IN);

   snake_btn_sync #(.W(4)) u_btn_sync (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn),
      .clr    (in_clr),
      .sticky (sticky)
   );

   // Out-of-range register indices read as zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (ra == 4'(i)) rd_a = regs[i];
         if (rb == 4'(i)) rd_b = regs[i];
      end
   end

   assign sum     = {1'b0, opa} + {1'b0, opb};
   assign diff    = {1'b0, opa} - {1'b0, opb};
   assign sum_imm = {1'b0, opa} + {1'b0, imm};

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_en    = 1'b0;
      wr_data  = '0;
      flag_nxt = flag;
      if (state == EXEC) begin
         case (op)
            OP_LDI:  begin wr_en = 1'b1; wr_data = imm; end
            OP_MOV:  begin wr_en = 1'b1; wr_data = opb; end
            OP_ADD:  begin wr_en = 1'b1; wr_data = sum[DATA_W-1:0];     flag_nxt = sum[DATA_W]; end
            OP_SUB:  begin wr_en = 1'b1; wr_data = diff[DATA_W-1:0];    flag_nxt = diff[DATA_W]; end
            OP_AND:  begin wr_en = 1'b1; wr_data = opa & opb; end
            OP_OR:   begin wr_en = 1'b1; wr_data = opa | opb; end
            OP_XOR:  begin wr_en = 1'b1; wr_data = opa ^ opb; end
            OP_ADDI: begin wr_en = 1'b1; wr_data = sum_imm[DATA_W-1:0]; flag_nxt = sum_imm[DATA_W]; end
            OP_CMP:  flag_nxt = (opa == opb);
            OP_IN:   begin wr_en = 1'b1; wr_data = DATA_W'(sticky); end
            OP_RND:  begin wr_en = 1'b1; wr_data = lfsr[DATA_W-1:0]; end
            default: ;
         endcase
      end
   end

   // NOTE: the register file is reset explicitly because programs rely on every register reading 0 after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            if (wr_en && ra == 4'(i)) regs[i] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FETCH;
         pc       <= '0;
         inst_q   <= '0;
         opa      <= '0;
         opb      <= '0;
         flag     <= 1'b0;
         imem_req <= 1'b0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_data  <= '0;
      end else begin
         fb_we <= 1'b0;
         case (state)
            FETCH: begin
               // A valid without an outstanding request is not a handshake.
               if (imem_req && imem_valid) begin
                  inst_q   <= imem_data;
                  pc       <= pc + 1'b1;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            DECODE: begin
               opa   <= rd_a;
               opb   <= rd_b;
               state <= EXEC;
               if (op == OP_OUT) begin
                  fb_we   <= 1'b1;
                  fb_addr <= rd_b[FB_AW-1:0];
                  fb_data <= rd_a;
               end
            end
            EXEC: begin
               flag <= flag_nxt;
               if (op == OP_JMP || (op == OP_JF && flag)) pc <= imm[PC_W-1:0];
               if (op == OP_HLT) begin
                  state <= HALT;
               end else begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            HALT:    ;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_cpu_core.sv
// Self-checking bench for snake_cpu_core: directed scenarios plus a random
// instruction stream checked against an arithmetic reference model.
module tb_snake_cpu_core;

   localparam int DATA_W = 8;
   localparam int PC_W   = 8;
   localparam int NREGS  = 8;
   localparam int FB_AW  = 3;
   localparam int INST_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_req;
   logic [INST_W-1:0] imem_data;
   logic              imem_valid;
   logic [3:0]        btn;
   logic              fb_we;
   logic [FB_AW-1:0]  fb_addr;
   logic [DATA_W-1:0] fb_data;
   logic              halted;

   snake_cpu_core #(
      .DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .FB_AW(FB_AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_data  (imem_data),
      .imem_valid (imem_valid),
      .btn        (btn),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state.
   int          m_regs [16];
   int          m_flag, m_pc, m_sticky, m_halted;
   logic [15:0] m_lfsr;

   // x^16 + x^14 + x^13 + x^11 + 1, shifted once per clock.
   always @(posedge clk or negedge reset) begin
      if (!reset) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rget(input int idx);
      return (idx < NREGS) ? m_regs[idx] : 0;
   endfunction

   task automatic rset(input int idx, input int v);
      if (idx < NREGS) m_regs[idx] = v & 255;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_flag = 0; m_pc = 0; m_sticky = 0; m_halted = 0;
   endtask

   task automatic model_exec(input logic [15:0] inst, input logic [15:0] lfsr_now, input logic [3:0] btn_set);
      int op, ra, rb, imm, a, b, r;
      op  = int'(inst[15:12]);
      ra  = int'(inst[11:8]);
      imm = int'(inst[7:0]);
      rb  = int'(inst[3:0]);
      a   = rget(ra);
      b   = rget(rb);
      m_pc = (m_pc + 1) % 256;
      case (op)
         1:  rset(ra, imm);
         2:  rset(ra, b);
         3:  begin r = a + b;   rset(ra, r); m_flag = int'(r > 255); end
         4:  begin r = a - b;   rset(ra, r); m_flag = int'(r < 0);   end
         5:  rset(ra, a & b);
         6:  rset(ra, a | b);
         7:  rset(ra, a ^ b);
         8:  begin r = a + imm; rset(ra, r); m_flag = int'(r > 255); end
         9:  m_flag = int'(a == b);
         10: m_pc = imm;
         11: if (m_flag != 0) m_pc = imm;
         12: rset(ra, m_sticky);
         13: rset(ra, int'(lfsr_now));
         15: m_halted = 1;
         default: ;
      endcase
      if (op == 12) m_sticky = int'(btn_set);
      else          m_sticky = m_sticky | int'(btn_set);
   endtask

   function automatic logic [15:0] mk(input int op, input int ra, input int imm);
      return {4'(op), 4'(ra), 8'(imm)};
   endfunction

   // One full instruction: handshake after 'stall' idle request cycles,
   // optionally raising btn bits on the handshake edge, then DECODE and EXEC.
   task automatic run(input logic [15:0] inst, input int stall, input logic [3:0] btn_set);
      int          waited;
      logic [15:0] lfsr_now;
      int          ra, rb;
      waited = 0;
      while (imem_req !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("req_seen", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_req", 32'(imem_req), 32'd1);
         chk("stall_addr", 32'(imem_addr), 32'(m_pc));
      end
      imem_data  = inst;
      imem_valid = 1'b1;
      btn        = btn | btn_set;
      @(negedge clk);
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = 16'($urandom);
      chk("decode_req", 32'(imem_req), 32'd0);
      chk("decode_fb_we", 32'(fb_we), 32'd0);
      @(negedge clk);
      lfsr_now = m_lfsr;
      ra = int'(inst[11:8]);
      rb = int'(inst[3:0]);
      chk("exec_fb_we", 32'(fb_we), 32'(inst[15:12] == 4'hE));
      if (inst[15:12] == 4'hE) begin
         chk("out_fb_addr", 32'(fb_addr), 32'(rget(rb) & 7));
         chk("out_fb_data", 32'(fb_data), 32'(rget(ra)));
      end
      model_exec(inst, lfsr_now, btn_set);
      @(negedge clk);
      imem_valid = 1'b0;
      chk("post_fb_we", 32'(fb_we), 32'd0);
      chk("halted", 32'(halted), 32'(m_halted));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_fb_we", 32'(fb_we), 32'd0);
      chk("rst_fb_addr", 32'(fb_addr), 32'd0);
      chk("rst_fb_data", 32'(fb_data), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("boot_req_low", 32'(imem_req), 32'd0);
      // A valid offered before any request must be ignored.
      imem_data  = mk(15, 0, 0);
      imem_valid = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("boot_req_high", 32'(imem_req), 32'd1);
      chk("boot_addr", 32'(imem_addr), 32'd0);
   endtask

   task automatic pulse_btn(input logic [3:0] bits);
      @(negedge clk);
      btn = bits;
      repeat (3) @(negedge clk);
      btn = 4'b0;
      repeat (3) @(negedge clk);
      m_sticky = m_sticky | int'(bits);
   endtask

   initial begin
      int waited;
      reset      = 1'b0;
      imem_valid = 1'b0;
      imem_data  = '0;
      btn        = 4'b0;
      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      // Carry-out add, first fetch stalled 5 cycles.
      run(mk(1, 1, 8'h05), 5, 4'b0);
      run(mk(1, 2, 8'hFE), 1, 4'b0);
      run(mk(3, 1, 2), 1, 4'b0);
      run(mk(14, 1, 0), 1, 4'b0);
      chk("add_result", 32'(fb_data), 32'h03);
      run(mk(11, 0, 8'h40), 1, 4'b0);
      chk("carry_flag_jf", 32'(imem_addr), 32'h40);
      run(mk(15, 0, 0), 1, 4'b0);
      chk("hlt_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 4; i++) begin
         imem_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("halt_req", 32'(imem_req), 32'd0);
         chk("halt_stays", 32'(halted), 32'd1);
      end
      imem_valid = 1'b0;

      // Branching taken, then not taken after a fresh reset.
      do_reset();
      run(mk(1, 0, 3), 0, 4'b0);
      run(mk(9, 0, 0), 0, 4'b0);
      run(mk(11, 0, 8'h10), 0, 4'b0);
      chk("jf_taken", 32'(imem_addr), 32'h10);
      do_reset();
      run(mk(1, 1, 4), 0, 4'b0);
      run(mk(9, 0, 1), 0, 4'b0);
      run(mk(11, 0, 8'h10), 0, 4'b0);
      chk("jf_not_taken", 32'(imem_addr), 32'h03);
      run(mk(10, 0, m_pc), 2, 4'b0);
      chk("jmp_self", 32'(imem_addr), 32'h03);

      // Frame-buffer write.
      run(mk(1, 3, 8'hA5), 0, 4'b0);
      run(mk(1, 4, 8'h0A), 0, 4'b0);
      run(mk(14, 3, 4), 0, 4'b0);
      chk("out_addr_hold", 32'(fb_addr), 32'd2);
      chk("out_data_hold", 32'(fb_data), 32'hA5);

      // Sticky buttons, including an edge coinciding with the IN clear.
      pulse_btn(4'b1000);
      run(mk(12, 5, 0), 0, 4'b0);
      run(mk(14, 5, 0), 0, 4'b0);
      chk("in_up", 32'(fb_data), 32'h08);
      run(mk(12, 5, 0), 0, 4'b0);
      run(mk(14, 5, 0), 0, 4'b0);
      chk("in_cleared", 32'(fb_data), 32'h00);
      run(mk(12, 6, 0), 0, 4'b0001);
      btn = 4'b0;
      repeat (3) @(negedge clk);
      run(mk(12, 6, 0), 0, 4'b0);
      run(mk(14, 6, 0), 0, 4'b0);
      chk("in_set_wins", 32'(fb_data), 32'h01);

      // Random instruction stream (no HLT), then dump the registers.
      for (int n = 0; n < 60; n++)
         run(mk($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 255)),
             $urandom_range(0, 3), 4'b0);
      for (int i = 0; i < 16; i++) run(mk(14, i, $urandom_range(0, 15)), 0, 4'b0);

      // Reset while an ADD sits in DECODE.
      run(mk(1, 1, 8'h11), 0, 4'b0);
      run(mk(1, 2, 8'h22), 0, 4'b0);
      run(mk(14, 2, 1), 0, 4'b0);
      waited = 0;
      while (imem_req !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      imem_data  = mk(3, 1, 2);
      imem_valid = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("mid_decode_req", 32'(imem_req), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_addr", 32'(imem_addr), 32'd0);
      chk("async_fb_addr", 32'(fb_addr), 32'd0);
      chk("async_fb_data", 32'(fb_data), 32'd0);
      chk("async_halted", 32'(halted), 32'd0);
      model_reset();
      @(negedge clk);
      imem_valid = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      reset = 1'b1;
      run(mk(14, 1, 2), 1, 4'b0);
      chk("no_add_write", 32'(fb_data), 32'h00);
      run(mk(15, 0, 0), 0, 4'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
